mips_fetch_queue: RTL and testbench
===================================

Name: mips_fetch_queue

Overview:
- Parametrised instruction-fetch stage with prefetch buffer; replaces the single IF/ID latch of the pipelined MIPS core with a DEPTH-entry FIFO of {PC+4, instruction} pairs.
- Sits between instruction memory and the decode/write-back stage.
- Decode consumes entries under a ready/valid handshake. A taken branch from decode flushes the queue and redirects the fetch PC.

Parameters:
- ADDR_W, 32, PC/address width in bits.
- INSTR_W, 32, instruction width in bits.
- DEPTH, 4, queue entries; power of two, >= 2.
- RESET_PC, 0, fetch PC after reset.
- PC_STEP, 4, PC increment per fetched instruction.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  ADDR_W  fetch address; equals the fetch PC register.
- imem_instr  in  INSTR_W  instruction at imem_addr, combinational same-cycle read.
- pc_hold  in  1  hazard stall from decode; blocks enqueue and PC advance.
- branch_taken  in  1  redirect/flush request from decode.
- branch_addr  in  ADDR_W  redirect target.
- id_ready  in  1  decode accepts the head entry this cycle.
- id_valid  out  1  head entry present.
- id_instr  out  INSTR_W  head instruction; 0 (NOP) when empty.
- id_pc4  out  ADDR_W  head PC+PC_STEP; 0 when empty.
- if_id  out  ADDR_W+INSTR_W  {id_pc4, id_instr}; same layout as the existing IF/ID bus.
- count  out  $clog2(DEPTH+1)  current occupancy.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (rst high at a clk edge):
  - pc <= RESET_PC; read/write pointers <= 0; count <= 0.
  - Resulting outputs: id_valid=0, id_instr=0, id_pc4=0, full=0, imem_addr=RESET_PC.
  - Reset overrides all other inputs, including branch_taken mid-flush.
- Definitions:
  - pop = id_valid & id_ready.
  - push = !pc_hold & !branch_taken & (!full | pop).
- On push:
  - Entry {pc+PC_STEP, imem_instr} is written at the write pointer.
  - pc <= pc+PC_STEP, wrapping modulo 2^ADDR_W.
  - Write pointer advances modulo DEPTH.
- On pop: read pointer advances modulo DEPTH.
- count update: +1 on push only; -1 on pop only; unchanged on push & pop together.
- Full with simultaneous pop: push is allowed and count stays DEPTH.
- Empty: no pop is possible. id_valid=0 and the outputs present a NOP bubble. There is no bypass: a fetched instruction becomes visible one cycle after its push.
- Branch (branch_taken=1, rst=0):
  - Pointers and count <= 0; pc <= branch_addr.
  - No push and no pop are counted that cycle. The head entry is discarded even if id_ready=1; decode owns the branch instruction already.
  - Next cycle: imem_addr=branch_addr and the queue is empty. The first post-branch instruction appears on id_* two cycles after branch_taken.
- pc_hold=1 and branch_taken=1 together: the branch wins; the flush and redirect occur.
- pc_hold=1 alone: pc frozen and no enqueue. Dequeue continues normally.
- id_ready=0: the head is stable and the id_* outputs hold their value until popped or flushed.
- Output timing: all outputs except imem_addr are driven from registers or storage indexed by the registered read pointer. There are no combinational paths from id_ready/branch_taken to the outputs.
- Latency: instruction at address A fetched at cycle t → visible on id_* at t+1, assuming the queue was empty.

Test Plan:
- Reset, then free-run with id_ready=1 and imem returning instr=addr|0xA5000000 → id_pc4 sequence 4, 8, 12…; id_valid high from cycle 2; count stays 1.
- id_ready=0 for 6 cycles after reset (DEPTH=4) → count reaches 4 and full=1; imem_addr freezes at 0x10; then one pop with id_ready=1 → a push occurs in the same cycle, count stays 4, imem_addr=0x14.
- Queue at count=3, branch_taken=1 with branch_addr=0x400 → next cycle count=0, id_valid=0, imem_addr=0x400; the following cycle id_pc4=0x404.
- pc_hold=1 for 3 cycles with id_ready=1 → queue drains to empty, id_instr=0, imem_addr unchanged; release → fetch resumes at the held address.
- branch_taken and pc_hold both high, branch_addr=0x80 → redirect to 0x80 occurs.
- rst asserted while full=1 and branch_taken=1 → next cycle count=0, imem_addr=RESET_PC.
- PC wrap: branch_addr=0xFFFFFFFC, then one push → id_pc4=0x00000000, next imem_addr=0x00000000.

Source files
------------

// File: rtl/mips_fetch_queue.sv
// mips_fetch_queue: instruction-fetch stage with a DEPTH-entry prefetch FIFO.
// Replaces the single IF/ID latch with a queue of {PC+PC_STEP, instruction} pairs
// that decode drains under a ready/valid handshake.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   imem_addr      fetch address (the fetch PC register)
//   imem_instr     instruction at imem_addr, combinational same-cycle read
//   pc_hold        decode hazard stall: freezes PC, blocks enqueue
//   branch_taken   flush queue and redirect fetch to branch_addr
//   branch_addr    redirect target
//   id_ready       decode accepts the head entry
//   id_valid       head entry present
//   id_instr       head instruction (0 / NOP when empty)
//   id_pc4         head PC+PC_STEP (0 when empty)
//   if_id          {id_pc4, id_instr}
//   count          queue occupancy
//   full           count == DEPTH
module mips_fetch_queue #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INSTR_W  = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        PC_STEP  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [ADDR_W-1:0]             imem_addr,
  input  logic [INSTR_W-1:0]            imem_instr,
  input  logic                          pc_hold,
  input  logic                          branch_taken,
  input  logic [ADDR_W-1:0]             branch_addr,
  input  logic                          id_ready,
  output logic                          id_valid,
  output logic [INSTR_W-1:0]            id_instr,
  output logic [ADDR_W-1:0]             id_pc4,
  output logic [ADDR_W+INSTR_W-1:0]     if_id,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH+1);
  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  r_pc;
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic [ENTRY_W-1:0] r_mem [DEPTH];

  logic               w_pop;
  logic               w_push;
  logic [ADDR_W-1:0]  w_pc_next;
  logic [ENTRY_W-1:0] w_head;

  // Handshake: a full queue still accepts a push when the head leaves this cycle.
  assign w_pop     = id_valid & id_ready;
  assign w_push    = ~pc_hold & ~branch_taken & (~full | w_pop);
  assign w_pc_next = r_pc + ADDR_W'(PC_STEP);

  // Control state: PC, pointers, occupancy. Reset beats branch beats normal flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (branch_taken) begin
      // Head is dropped even if id_ready is high; decode already holds the branch.
      r_pc    <= branch_addr;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc   <= w_pc_next;
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; no reset needed since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wptr] <= {w_pc_next, imem_instr};
    end
  end

  // Outputs come only from registers and storage at the registered read pointer.
  assign w_head    = r_mem[r_rptr];
  assign imem_addr = r_pc;
  assign count     = r_count;
  assign full      = (r_count == CNT_W'(DEPTH));
  assign id_valid  = (r_count != '0);
  assign if_id     = id_valid ? w_head : '0;
  assign id_pc4    = if_id[ENTRY_W-1:INSTR_W];
  assign id_instr  = if_id[INSTR_W-1:0];

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Testbench for mips_fetch_queue (DEPTH=4, 32-bit PC/instr, PC_STEP=4).
// Instruction memory returns addr | 0xA5000000. Expected entries are pushed
// to a scoreboard as stimulus is driven and compared when decode pops them.
module tb_mips_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        pc_hold;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic [63:0] if_id;
  logic [2:0]  count;
  logic        full;

  int          errors = 0;
  int          checks = 0;
  logic        mon_en = 1'b0;

  logic [63:0] sb[$];
  logic [31:0] m_pc;
  int          m_count;

  mips_fetch_queue #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .pc_hold(pc_hold), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc4(id_pc4), .if_id(if_id), .count(count), .full(full)
  );

  assign imem_instr = imem_addr | 32'hA500_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every accepted head must match the oldest expected entry.
  always @(negedge clk) begin
    if (mon_en && !rst && !branch_taken && id_valid && id_ready) begin
      logic [63:0] exp_e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_pop: got pop of %h required no pop (scoreboard empty)", if_id);
      end else begin
        exp_e = sb.pop_front();
        if (if_id !== exp_e) begin
          errors++;
          $display("FAIL sb_entry: got %h required %h", if_id, exp_e);
        end
      end
    end
  end

  // Apply one cycle of stimulus, advance the reference model, wait past the edge.
  task automatic drive(input logic hold, input logic br, input logic [31:0] baddr,
                       input logic rdy);
    logic m_full, m_pop, m_push;
    rst = 1'b0; pc_hold = hold; branch_taken = br; branch_addr = baddr; id_ready = rdy;
    m_full = (m_count == DEPTH);
    m_pop  = (m_count != 0) && rdy;
    m_push = !hold && !br && (!m_full || m_pop);
    if (br) begin
      sb.delete();
      m_count = 0;
      m_pc    = baddr;
    end else begin
      if (m_push) begin
        sb.push_back({m_pc + 32'd4, m_pc | 32'hA500_0000});
        m_pc = m_pc + 32'd4;
      end
      m_count = m_count + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset(input logic br, input logic rdy);
    rst = 1'b1; pc_hold = 1'b0; branch_taken = br; branch_addr = 32'h200; id_ready = rdy;
    @(posedge clk); #1;
    sb.delete();
    m_count = 0;
    m_pc    = 32'h0;
  endtask

  task automatic test_reset();
    apply_reset(1'b0, 1'b0);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", count); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h required 0", id_instr); end
    checks++; if (id_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h required 0", id_pc4); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b required 0", full); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h required 0", imem_addr); end
  endtask

  task automatic test_free_run();
    apply_reset(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL free_count[%0d]: got %0d required 1", i, count); end
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL free_valid[%0d]: got %b required 1", i, id_valid); end
      checks++; if (id_pc4 !== 32'(4*(i+1))) begin errors++; $display("FAIL free_pc4[%0d]: got %h required %h", i, id_pc4, 32'(4*(i+1))); end
      checks++; if (id_instr !== (32'(4*i) | 32'hA500_0000)) begin errors++; $display("FAIL free_instr[%0d]: got %h required %h", i, id_instr, 32'(4*i) | 32'hA500_0000); end
    end
  endtask

  task automatic test_fill();
    apply_reset(1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (count !== 3'((k < 4) ? k : 4)) begin errors++; $display("FAIL fill_count[%0d]: got %0d required %0d", k, count, (k < 4) ? k : 4); end
      checks++; if (id_pc4 !== 32'h4) begin errors++; $display("FAIL fill_head[%0d]: got %h required 4", k, id_pc4); end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b required 1", full); end
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL fill_addr: got %h required 10", imem_addr); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpop_count: got %0d required 4", count); end
    checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL fullpop_addr: got %h required 14", imem_addr); end
    checks++; if (id_pc4 !== 32'h8) begin errors++; $display("FAIL fullpop_head: got %h required 8", id_pc4); end
  endtask

  task automatic test_branch_flush();
    apply_reset(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL br_pre_count: got %0d required 3", count); end
    drive(1'b0, 1'b1, 32'h400, 1'b1);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL br_count: got %0d required 0", count); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL br_valid: got %b required 0", id_valid); end
    checks++; if (imem_addr !== 32'h400) begin errors++; $display("FAIL br_addr: got %h required 400", imem_addr); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (id_pc4 !== 32'h404) begin errors++; $display("FAIL br_pc4: got %h required 404", id_pc4); end
    checks++; if (id_instr !== 32'hA500_0400) begin errors++; $display("FAIL br_instr: got %h required a5000400", id_instr); end
  endtask

  task automatic test_hold();
    apply_reset(1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      checks++; if (count !== 3'((k < 2) ? 1 : 0)) begin errors++; $display("FAIL hold_count[%0d]: got %0d required %0d", k, count, (k < 2) ? 1 : 0); end
      checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL hold_addr[%0d]: got %h required 8", k, imem_addr); end
    end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL hold_nop: got %h required 0", id_instr); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL hold_valid: got %b required 0", id_valid); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (id_pc4 !== 32'hC) begin errors++; $display("FAIL hold_resume_pc4: got %h required c", id_pc4); end
    checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL hold_resume_addr: got %h required c", imem_addr); end
  endtask

  task automatic test_branch_hold();
    drive(1'b1, 1'b1, 32'h80, 1'b1);
    checks++; if (imem_addr !== 32'h80) begin errors++; $display("FAIL brhold_addr: got %h required 80", imem_addr); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL brhold_count: got %0d required 0", count); end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (id_pc4 !== 32'h84) begin errors++; $display("FAIL brhold_pc4: got %h required 84", id_pc4); end
  endtask

  task automatic test_reset_mid_flush();
    apply_reset(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL rstbr_prefull: got %b required 1", full); end
    apply_reset(1'b1, 1'b1);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstbr_count: got %0d required 0", count); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rstbr_addr: got %h required 0", imem_addr); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rstbr_full: got %b required 0", full); end
  endtask

  task automatic test_pc_wrap();
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target: got %h required fffffffc", imem_addr); end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (id_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h required 0", id_pc4); end
    checks++; if (id_instr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr: got %h required fffffffc", id_instr); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h required 0", imem_addr); end
  endtask

  task automatic test_back_to_back();
    logic hold, br, rdy;
    logic [31:0] baddr;
    apply_reset(1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      hold  = ($urandom_range(0, 3) == 0);
      br    = ($urandom_range(0, 15) == 0);
      rdy   = ($urandom_range(0, 2) != 0);
      baddr = $urandom & 32'h0000_FFFC;
      drive(hold, br, baddr, rdy);
      checks++;
      if ({count, full, id_valid, imem_addr} !==
          {3'(m_count), (m_count == DEPTH), (m_count != 0), m_pc}) begin
        errors++;
        $display("FAIL b2b_state[%0d]: got count=%0d full=%b valid=%b addr=%h required count=%0d addr=%h",
                 i, count, full, id_valid, imem_addr, m_count, m_pc);
      end
    end
    for (int k = 0; k <= DEPTH; k++) drive(1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: got %0d entries left required 0", sb.size());
    end
  endtask

  initial begin
    rst = 1'b1; pc_hold = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0; id_ready = 1'b0;
    m_pc = 32'h0; m_count = 0;
    mon_en = 1'b1;
    test_reset();
    test_free_run();
    test_fill();
    test_branch_flush();
    test_hold();
    test_branch_hold();
    test_reset_mid_flush();
    test_pc_wrap();
    test_back_to_back();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
